// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped peripheral: register offsets, control/status bit
// positions and the offset decoder used by the top level.
package mmio_pkg;

  localparam logic [7:0] OFF_DISP   = 8'h00;
  localparam logic [7:0] OFF_BTN    = 8'h04;
  localparam logic [7:0] OFF_EDGE   = 8'h08;
  localparam logic [7:0] OFF_CYCLES = 8'h0C;
  localparam logic [7:0] OFF_TLOAD  = 8'h10;
  localparam logic [7:0] OFF_TCTRL  = 8'h14;
  localparam logic [7:0] OFF_STATUS = 8'h18;
  localparam logic [7:0] OFF_TCOUNT = 8'h1C;

  localparam int unsigned TCTRL_EN       = 0;
  localparam int unsigned TCTRL_ONESHOT  = 1;
  localparam int unsigned STATUS_EXPIRED = 0;

  typedef enum logic [3:0] {
    SelDisp,
    SelBtn,
    SelEdge,
    SelCycles,
    SelTload,
    SelTctrl,
    SelStatus,
    SelTcount,
    SelNone
  } reg_sel_e;

  // Byte-lane bits are masked so any byte address inside a word selects that word.
  function automatic reg_sel_e decode_offset(logic [7:0] off);
    unique case (off & 8'hFC)
      OFF_DISP:   return SelDisp;
      OFF_BTN:    return SelBtn;
      OFF_EDGE:   return SelEdge;
      OFF_CYCLES: return SelCycles;
      OFF_TLOAD:  return SelTload;
      OFF_TCTRL:  return SelTctrl;
      OFF_STATUS: return SelStatus;
      OFF_TCOUNT: return SelTcount;
      default:    return SelNone;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: 2-flop synchronizer, then a stability counter that must run
// DEBOUNCE_CYCLES before the accepted level follows the input. rise pulses on a 0->1 accept.
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic level,
  output logic rise
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic [15:0] cnt_q, cnt_d;
  logic        accept;

  assign accept = (sync2_q != level_q) && (cnt_q == DEBOUNCE_CYCLES - 16'd1);

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (accept) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = accept && sync2_q;

endmodule

// File: rtl/mmio_peripheral.sv
// Peripheral window on the data-memory bus: display register, debounced buttons with sticky
// edge flags, free-running cycle counter and a reloadable down-timer.
module mmio_peripheral
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
  parameter int unsigned NUM_BTN         = 4,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               hit,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [31:0]        disp_value,
  output logic               timer_flag
);

  logic [NUM_BTN-1:0] btn_level, btn_rise;
  logic [NUM_BTN-1:0] edge_q, edge_d;
  logic [31:0]        disp_q, disp_d;
  logic [31:0]        cycles_q, cycles_d;
  logic [31:0]        tload_q, tload_d;
  logic [31:0]        tcount_q, tcount_d;
  logic               en_q, en_d;
  logic               oneshot_q, oneshot_d;
  logic               expired_q, expired_d;
  logic               expire_set;
  logic               wr;
  reg_sel_e           sel;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (clk),
      .reset(reset),
      .in   (btn_in[i]),
      .level(btn_level[i]),
      .rise (btn_rise[i])
    );
  end

  assign hit = (address[31:8] == BASE_ADDR[31:8]);
  assign sel = decode_offset(address[7:0]);
  assign wr  = we && hit;

  always_comb begin
    disp_d     = disp_q;
    tload_d    = tload_q;
    cycles_d   = cycles_q + 32'd1;
    edge_d     = edge_q;
    en_d       = en_q;
    oneshot_d  = oneshot_q;
    tcount_d   = tcount_q;
    expired_d  = expired_q;
    expire_set = 1'b0;

    if (en_q) begin
      if (tcount_q == '0) begin
        expire_set = 1'b1;
        if (oneshot_q) begin
          en_d = 1'b0;
        end else begin
          tcount_d = tload_q;
        end
      end else begin
        tcount_d = tcount_q - 32'd1;
      end
    end

    if (wr) begin
      unique case (sel)
        SelDisp:   disp_d = write_data;
        SelEdge:   edge_d = edge_q & ~write_data[NUM_BTN-1:0];
        SelCycles: cycles_d = write_data;
        SelTload:  tload_d = write_data;
        SelTctrl: begin
          en_d      = write_data[TCTRL_EN];
          oneshot_d = write_data[TCTRL_ONESHOT];
          // Only an off->on transition restarts the count; re-writing EN=1 leaves it running.
          if (write_data[TCTRL_EN] && !en_q) tcount_d = tload_q;
        end
        SelStatus: if (write_data[STATUS_EXPIRED]) expired_d = 1'b0;
        default: ;
      endcase
    end

    // Hardware sets take priority over a same-cycle write-1-clear.
    edge_d = edge_d | btn_rise;
    if (expire_set) expired_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q    <= '0;
      edge_q    <= '0;
      cycles_q  <= '0;
      tload_q   <= '0;
      tcount_q  <= '0;
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      disp_q    <= disp_d;
      edge_q    <= edge_d;
      cycles_q  <= cycles_d;
      tload_q   <= tload_d;
      tcount_q  <= tcount_d;
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    read_data = '0;
    if (hit) begin
      unique case (sel)
        SelDisp:   read_data = disp_q;
        SelBtn:    read_data = 32'(btn_level);
        SelEdge:   read_data = 32'(edge_q);
        SelCycles: read_data = cycles_q;
        SelTload:  read_data = tload_q;
        SelTctrl: begin
          read_data[TCTRL_EN]      = en_q;
          read_data[TCTRL_ONESHOT] = oneshot_q;
        end
        SelStatus: read_data[STATUS_EXPIRED] = expired_q;
        SelTcount: read_data = tcount_q;
        default:   read_data = '0;
      endcase
    end
  end

  assign disp_value = disp_q;
  assign timer_flag = expired_q;

endmodule
